// File: rtl/ahb_coeff_loader.sv
// ahb_coeff_loader
//   AHB-Lite master that loads FIR coefficients received on an AXI-Stream
//   slave port. The filter is disabled through its control register, each
//   coefficient is written as one SINGLE halfword transfer, and the filter is
//   then re-enabled with the requested rate.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   ce                    clock enable for start and stream acceptance
//   start, ntaps, rate    job request (sampled in IDLE only)
//   tdata_s/tvalid_s/tready_s   coefficient stream (signed Q15)
//   haddr_m .. hwdata_m   AHB-Lite master request outputs (all registered)
//   hready_m, hresp_m     AHB-Lite slave response
//   busy, done, error     job status
module ahb_coeff_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] CTRL_ADDR = 32'h0000_0400,
    parameter int          MAX_TAPS  = 512
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        start,
    input  logic [9:0]  ntaps,
    input  logic [15:0] rate,
    input  logic [15:0] tdata_s,
    input  logic        tvalid_s,
    output logic        tready_s,
    output logic [31:0] haddr_m,
    output logic [2:0]  hburst_m,
    output logic [2:0]  hsize_m,
    output logic [1:0]  htrans_m,
    output logic        hwrite_m,
    output logic [31:0] hwdata_m,
    input  logic        hready_m,
    input  logic        hresp_m,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [9:0] MAX_N         = 10'(MAX_TAPS);

    typedef enum logic [3:0] {
        S_IDLE, S_C0_ADDR, S_C0_DATA, S_FETCH, S_W_ADDR, S_W_DATA,
        S_C1_ADDR, S_C1_DATA, S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [9:0]  ntaps_q, ntaps_d;
    logic [15:0] rate_q, rate_d;
    logic [9:0]  idx_q, idx_d;
    logic [15:0] coeff_q, coeff_d;
    logic [31:0] haddr_q, haddr_d;
    logic [2:0]  hsize_q, hsize_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        hwrite_q, hwrite_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic        tready_q, tready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            ntaps_q  <= '0;
            rate_q   <= '0;
            idx_q    <= '0;
            coeff_q  <= '0;
            haddr_q  <= '0;
            hsize_q  <= '0;
            htrans_q <= HTRANS_IDLE;
            hwrite_q <= 1'b0;
            hwdata_q <= '0;
            tready_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ntaps_q  <= ntaps_d;
            rate_q   <= rate_d;
            idx_q    <= idx_d;
            coeff_q  <= coeff_d;
            haddr_q  <= haddr_d;
            hsize_q  <= hsize_d;
            htrans_q <= htrans_d;
            hwrite_q <= hwrite_d;
            hwdata_q <= hwdata_d;
            tready_q <= tready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ntaps_d  = ntaps_q;
        rate_d   = rate_q;
        idx_d    = idx_q;
        coeff_d  = coeff_q;
        error_d  = error_q;
        haddr_d  = haddr_q;
        hsize_d  = hsize_q;
        hwdata_d = hwdata_q;
        htrans_d = HTRANS_IDLE;
        hwrite_d = 1'b0;
        tready_d = 1'b0;

        // next-state
        case (state_q)
            S_IDLE: begin
                if (start && ce) begin
                    state_d = S_C0_ADDR;
                    ntaps_d = ({22'd0, ntaps} > MAX_TAPS) ? MAX_N : ntaps;
                    rate_d  = rate;
                    error_d = 1'b0;
                    idx_d   = '0;
                end
            end
            S_C0_ADDR: if (hready_m) state_d = S_C0_DATA;
            S_C0_DATA: begin
                // ERROR aborts at once; the filter stays disabled
                if (hresp_m) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else if (hready_m) begin
                    state_d = (ntaps_q == '0) ? S_C1_ADDR : S_FETCH;
                end
            end
            S_FETCH: begin
                // handshake uses the registered ready that the source sees
                if (tvalid_s && tready_q) begin
                    coeff_d = tdata_s;
                    state_d = S_W_ADDR;
                end
            end
            S_W_ADDR: if (hready_m) state_d = S_W_DATA;
            S_W_DATA: begin
                if (hresp_m) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else if (hready_m) begin
                    if (idx_q == ntaps_q - 10'd1) begin
                        state_d = S_C1_ADDR;
                    end else begin
                        idx_d   = idx_q + 10'd1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_C1_ADDR: if (hready_m) state_d = S_C1_DATA;
            S_C1_DATA: begin
                if (hresp_m) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else if (hready_m) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so the registered bus
        // signals line up with the state they belong to.
        case (state_d)
            S_C0_ADDR, S_C1_ADDR: begin
                htrans_d = HTRANS_NONSEQ;
                hwrite_d = 1'b1;
                haddr_d  = CTRL_ADDR;
                hsize_d  = HSIZE_WORD;
            end
            S_W_ADDR: begin
                htrans_d = HTRANS_NONSEQ;
                hwrite_d = 1'b1;
                haddr_d  = BASE_ADDR + {21'd0, idx_d, 1'b0};
                hsize_d  = HSIZE_HALF;
            end
            S_C0_DATA: if (state_q != S_C0_DATA) hwdata_d = {rate_d, 16'h0000};
            S_W_DATA:  if (state_q != S_W_DATA)  hwdata_d = {coeff_d, coeff_d};
            S_C1_DATA: if (state_q != S_C1_DATA) hwdata_d = {rate_d, 16'h0001};
            S_FETCH:   tready_d = ce;
            default:   ;
        endcase
    end

    assign busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    assign done_d = (state_d == S_DONE);

    assign tready_s = tready_q;
    assign haddr_m  = haddr_q;
    assign hburst_m = 3'b000;
    assign hsize_m  = hsize_q;
    assign htrans_m = htrans_q;
    assign hwrite_m = hwrite_q;
    assign hwdata_m = hwdata_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_ahb_coeff_loader.sv
// Directed bench for ahb_coeff_loader. A negedge process acts as AHB slave,
// transfer logger and stream source; the main process runs the jobs.
module tb_ahb_coeff_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  ntaps = '0;
    logic [15:0] rate = '0;
    logic [15:0] tdata_s = '0;
    logic        tvalid_s = 1'b0;
    logic        tready_s;
    logic [31:0] haddr_m;
    logic [2:0]  hburst_m;
    logic [2:0]  hsize_m;
    logic [1:0]  htrans_m;
    logic        hwrite_m;
    logic [31:0] hwdata_m;
    logic        hready_m = 1'b1;
    logic        hresp_m = 1'b0;
    logic        busy, done, error;

    ahb_coeff_loader #(.MAX_TAPS(6)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .start(start), .ntaps(ntaps),
        .rate(rate), .tdata_s(tdata_s), .tvalid_s(tvalid_s), .tready_s(tready_s),
        .haddr_m(haddr_m), .hburst_m(hburst_m), .hsize_m(hsize_m),
        .htrans_m(htrans_m), .hwrite_m(hwrite_m), .hwdata_m(hwdata_m),
        .hready_m(hready_m), .hresp_m(hresp_m), .busy(busy), .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // job configuration (written by main only)
    logic [15:0] coef [0:15];
    int n_coef = 0, ws = 0, err_at = -1, clr_seq = 0, t0 = 0;
    bit gap = 0, ce_trig = 0;

    // observation state (written by the negedge process only)
    int cyc = 0, seen_seq = 0, done_cyc = -1, done_cnt = 0;
    int wr_n = 0, wait_total = 0, fetch_cyc = 0, wcnt = 0, s_idx = 0, ce_left = 0;
    bit dphase = 0, tog = 0, vld_prev = 0, rdy_prev = 0, ce_used = 0;
    bit tready_seen = 0, wa2_seen = 0;
    logic [31:0] paddr = '0;
    logic [2:0]  psize = '0;
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];
    logic [2:0]  log_size [$];

    initial forever begin
        @(negedge clk);
        cyc++;
        if (clr_seq != seen_seq) begin
            seen_seq = clr_seq;
            wr_n = 0; wait_total = 0; fetch_cyc = 0; s_idx = 0; dphase = 0;
            done_cnt = 0; done_cyc = -1; tready_seen = 0; wa2_seen = 0;
            vld_prev = 0; rdy_prev = 0; ce_used = 0; ce_left = 0;
            log_addr.delete(); log_data.delete(); log_size.delete();
        end
        if (!reset_n) begin
            dphase = 0; hready_m = 1'b1; hresp_m = 1'b0;
        end else begin
            if (done) begin done_cyc = cyc - t0; done_cnt++; end
            if (tready_s) tready_seen = 1;
            if (htrans_m == 2'b10 && hsize_m == 3'b001 && haddr_m == 32'h4) wa2_seen = 1;
            if (dphase) begin
                if (wcnt < ws) begin
                    hready_m = 1'b0; hresp_m = 1'b0; wcnt++; wait_total++;
                    chk("addr_hold", haddr_m, paddr);
                end else begin
                    hready_m = 1'b1;
                    hresp_m  = (wr_n == err_at);
                    log_addr.push_back(paddr);
                    log_data.push_back(hwdata_m);
                    log_size.push_back(psize);
                    wr_n++; dphase = 0;
                end
            end else if (htrans_m == 2'b10) begin
                chk("hwrite", 32'(hwrite_m), 32'd1);
                hready_m = 1'b1; hresp_m = 1'b0;
                paddr = haddr_m; psize = hsize_m; dphase = 1; wcnt = 0;
            end else begin
                hready_m = 1'b1; hresp_m = 1'b0;
                if (busy) fetch_cyc++;
            end
        end
        // stream source: handshake of the edge just passed
        if (vld_prev && rdy_prev) s_idx++;
        if (ce_trig && !ce_used && fetch_cyc >= 2) begin ce_left = 3; ce_used = 1; end
        if (ce_left > 0) begin ce = 1'b0; ce_left--; end
        else ce = 1'b1;
        tvalid_s = (s_idx < n_coef) && (!gap || tog);
        tdata_s  = (s_idx < n_coef && s_idx < 16) ? coef[s_idx] : 16'h0;
        tog = !tog;
        vld_prev = tvalid_s;
        rdy_prev = tready_s;
    end

    task automatic run_job(input int n_req, input logic [15:0] r, input int nc,
                           input int w, input int ea, input bit g, input bit cet);
        bit fin;
        @(negedge clk); #1;
        n_coef = nc; ws = w; err_at = ea; gap = g; ce_trig = cet;
        clr_seq++;
        ntaps = 10'(n_req); rate = r; start = 1'b1; t0 = cyc;
        @(negedge clk); #1;
        start = 1'b0;
        fin = 0;
        for (int k = 0; k < 400; k++) begin
            if (done_cnt > 0 || (!busy && error)) begin fin = 1; break; end
            @(negedge clk); #1;
        end
        chk("job_end", 32'(fin), 32'd1);
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic chk_seq(input string tag, input int n, input logic [15:0] r);
        chk({tag, "_nwr"}, 32'(log_addr.size()), 32'(n + 2));
        if (log_addr.size() == n + 2) begin
            chk({tag, "_c0a"}, log_addr[0], 32'h400);
            chk({tag, "_c0d"}, log_data[0], {r, 16'h0000});
            chk({tag, "_c0s"}, 32'(log_size[0]), 32'd2);
            for (int i = 0; i < n; i++) begin
                chk({tag, "_wa"}, log_addr[i + 1], 32'(2 * i));
                chk({tag, "_wd"}, log_data[i + 1], {coef[i], coef[i]});
                chk({tag, "_ws"}, 32'(log_size[i + 1]), 32'd1);
            end
            chk({tag, "_c1a"}, log_addr[n + 1], 32'h400);
            chk({tag, "_c1d"}, log_data[n + 1], {r, 16'h0001});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values
        #1;
        chk("rst_htrans", 32'(htrans_m), 32'd0);
        chk("rst_hwrite", 32'(hwrite_m), 32'd0);
        chk("rst_haddr", haddr_m, 32'd0);
        chk("rst_hwdata", hwdata_m, 32'd0);
        chk("rst_hsize", 32'(hsize_m), 32'd0);
        chk("rst_hburst", 32'(hburst_m), 32'd0);
        chk("rst_flags", {28'd0, tready_s, busy, done, error}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // four coefficients, zero-wait slave
        for (int i = 0; i < 4; i++) coef[i] = 16'(i + 1);
        run_job(4, 16'h0010, 4, 0, -1, 0, 0);
        chk_seq("t1", 4, 16'h0010);
        if (log_data.size() == 6) begin
            chk("t1_c0", log_data[0], 32'h0010_0000);
            chk("t1_w3", log_data[4], 32'h0004_0004);
            chk("t1_c1", log_data[5], 32'h0010_0001);
        end
        chk("t1_done_cyc", 32'(done_cyc), 32'd17);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);
        chk("t1_error", 32'(error), 32'd0);
        chk("t1_hburst", 32'(hburst_m), 32'd0);

        // empty job: only the two CTRL writes
        run_job(0, 16'h0022, 0, 0, -1, 0, 0);
        chk_seq("t2", 0, 16'h0022);
        chk("t2_tready", 32'(tready_seen), 32'd0);
        chk("t2_done_cyc", 32'(done_cyc), 32'd5);

        // two wait states on each of the four data phases
        coef[0] = 16'h8001; coef[1] = 16'h7fff;
        run_job(2, 16'h0abc, 2, 2, -1, 0, 0);
        chk_seq("t3", 2, 16'h0abc);
        chk("t3_waits", 32'(wait_total), 32'd8);
        chk("t3_done_cyc", 32'(done_cyc), 32'd19);

        // ERROR response on the data phase of coefficient 1 (third write)
        for (int i = 0; i < 3; i++) coef[i] = 16'(16'h0100 * (i + 1));
        run_job(3, 16'h0005, 3, 0, 2, 0, 0);
        chk("t4_nwr", 32'(log_addr.size()), 32'd3);
        chk("t4_error", 32'(error), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_done", 32'(done_cnt), 32'd0);
        chk("t4_htrans", 32'(htrans_m), 32'd0);
        run_job(0, 16'h0006, 0, 0, -1, 0, 0);
        chk("t4_err_clr", 32'(error), 32'd0);
        chk("t4_rerun_done", 32'(done_cyc), 32'd5);

        // stream gaps plus ce low for three cycles in FETCH
        coef[0] = 16'h1234; coef[1] = 16'hfedc; coef[2] = 16'h0f0f;
        run_job(3, 16'h0777, 3, 0, -1, 1, 1);
        chk_seq("t5", 3, 16'h0777);
        chk("t5_stalls", 32'(fetch_cyc - 3 >= 3), 32'd1);
        chk("t5_done_cyc", 32'(done_cyc), 32'(14 + (fetch_cyc - 3)));

        // ntaps above MAX_TAPS (6 here) is clamped
        for (int i = 0; i < 9; i++) coef[i] = 16'(16'h0111 * i);
        run_job(9, 16'h0042, 9, 0, -1, 0, 0);
        chk_seq("t6", 6, 16'h0042);
        chk("t6_done_cyc", 32'(done_cyc), 32'd23);

        // reset during W_ADDR of coefficient 2
        begin
            bit hit, idle_ok;
            for (int i = 0; i < 4; i++) coef[i] = 16'(16'h0a00 + i);
            @(negedge clk); #1;
            n_coef = 4; ws = 0; err_at = -1; gap = 0; ce_trig = 0;
            clr_seq++;
            ntaps = 10'd4; rate = 16'h0003; start = 1'b1; t0 = cyc;
            @(negedge clk); #1;
            start = 1'b0;
            hit = 0;
            for (int k = 0; k < 100; k++) begin
                if (wa2_seen) begin hit = 1; break; end
                @(negedge clk); #1;
            end
            chk("t7_reach_w2", 32'(hit), 32'd1);
            reset_n = 1'b0;
            #1;
            chk("t7_htrans", 32'(htrans_m), 32'd0);
            chk("t7_busy", 32'(busy), 32'd0);
            chk("t7_outs", {haddr_m[30:0], hwrite_m}, 32'd0);
            repeat (2) @(negedge clk);
            #1;
            reset_n = 1'b1;
            idle_ok = 1;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk); #1;
                if (busy || htrans_m != 2'b00 || tready_s) idle_ok = 0;
            end
            chk("t7_stay_idle", 32'(idle_ok), 32'd1);
            chk("t7_no_done", 32'(done_cnt), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
